bc_dat_write_rmw: RTL and testbench

Store-side counterpart to the sub-word read/extract logic. It accepts byte, halfword, word and (64-bit only) doubleword store requests on a valid/ready interface and lane-aligns the LSB-justified store data. It drives a single-port memory that has no byte enables, doing a read-modify-write (RMW) for partial stores and a direct write for full-width stores. It sits between the core LSU store path and the data SRAM wrapper.

---
 rtl/bc_dat_write_rmw_if.sv | 39 +++
 rtl/bc_dat_write_rmw.sv | 157 +++++++++++++++
 tb/tb_bc_dat_write_rmw.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bc_dat_write_rmw_if.sv
// ============================================================================
// Module : bc_dat_write_rmw_if
// Brief  : Store-request handshake and single-port memory bus bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bc_dat_write_rmw_if #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 10,
  localparam int WIDTH_OFS = $clog2(WIDTH_DATA / 8)
);
  logic                            iReqVld;
  logic                            oReqRdy;
  logic [WIDTH_ADDR+WIDTH_OFS-1:0] iAddr;
  logic [1:0]                      iSize;
  logic [WIDTH_DATA-1:0]           iDat;
  logic                            oMemEn;
  logic                            oMemWr;
  logic [WIDTH_ADDR-1:0]           oMemAddr;
  logic [WIDTH_DATA-1:0]           oMemWDat;
  logic [WIDTH_DATA-1:0]           iMemRDat;
  logic                            oDone;
  logic                            oErr;

  // Store block side
  modport slave (
    input  iReqVld, iAddr, iSize, iDat, iMemRDat,
    output oReqRdy, oMemEn, oMemWr, oMemAddr, oMemWDat, oDone, oErr
  );

  // LSU / SRAM side
  modport master (
    output iReqVld, iAddr, iSize, iDat, iMemRDat,
    input  oReqRdy, oMemEn, oMemWr, oMemAddr, oMemWDat, oDone, oErr
  );
endinterface

`default_nettype wire

// File: rtl/bc_dat_write_rmw.sv
// ============================================================================
// Module : bc_dat_write_rmw
// Brief  : Sub-word store with read-modify-write on a byte-enable-less SRAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bc_dat_write_rmw #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 10
) (
  input wire logic           clk,
  input wire logic           rst_n,
  bc_dat_write_rmw_if.slave  bus
);
  localparam int WIDTH_OFS = $clog2(WIDTH_DATA / 8);
  localparam int NUM_LANES = WIDTH_DATA / 8;
  localparam logic [1:0] c_SIZE_FULL = 2'(WIDTH_OFS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    MRG  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t                rState;
  logic [WIDTH_OFS-1:0]  rOfs;
  logic [1:0]            rSize;
  logic [WIDTH_DATA-1:0] rDat;
  logic                  rMemEn;
  logic                  rMemWr;
  logic [WIDTH_ADDR-1:0] rMemAddr;
  logic [WIDTH_DATA-1:0] rMemWDat;
  logic                  rDone;
  logic                  rErr;

  logic [WIDTH_OFS-1:0]  wReqOfs;
  logic [WIDTH_ADDR-1:0] wReqWord;
  logic [WIDTH_OFS-1:0]  wAlignMask;
  logic                  wErr;
  logic                  wFull;
  logic [NUM_LANES-1:0]  wLaneBase;
  logic [NUM_LANES-1:0]  wLaneMask;
  logic [WIDTH_DATA-1:0] wBitMask;
  logic [WIDTH_DATA-1:0] wAligned;
  logic [WIDTH_DATA-1:0] wMerged;

  assign wReqOfs  = bus.iAddr[WIDTH_OFS-1:0];
  assign wReqWord = bus.iAddr[WIDTH_ADDR+WIDTH_OFS-1:WIDTH_OFS];

  // Low offset bits that must be zero for a naturally aligned access
  always_comb begin
    wAlignMask = '0;
    case (bus.iSize)
      2'd0:    wAlignMask = WIDTH_OFS'(3'b000);
      2'd1:    wAlignMask = WIDTH_OFS'(3'b001);
      2'd2:    wAlignMask = WIDTH_OFS'(3'b011);
      default: wAlignMask = WIDTH_OFS'(3'b111);
    endcase
  end

  assign wErr  = (bus.iSize > c_SIZE_FULL) || ((wReqOfs & wAlignMask) != '0);
  assign wFull = (bus.iSize == c_SIZE_FULL);

  always_comb begin
    wLaneBase = '0;
    case (rSize)
      2'd0:    wLaneBase = NUM_LANES'(8'h01);
      2'd1:    wLaneBase = NUM_LANES'(8'h03);
      2'd2:    wLaneBase = NUM_LANES'(8'h0F);
      default: wLaneBase = NUM_LANES'(8'hFF);
    endcase
  end

  assign wLaneMask = wLaneBase << rOfs;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign wBitMask[gi*8 +: 8] = {8{wLaneMask[gi]}};
    end
  endgenerate

  // Bits of rDat above the store size fall outside the lane mask
  assign wAligned = rDat << {rOfs, 3'b000};
  assign wMerged  = (bus.iMemRDat & ~wBitMask) | (wAligned & wBitMask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rState   <= IDLE;
      rOfs     <= '0;
      rSize    <= '0;
      rDat     <= '0;
      rMemEn   <= 1'b0;
      rMemWr   <= 1'b0;
      rMemAddr <= '0;
      rMemWDat <= '0;
      rDone    <= 1'b0;
      rErr     <= 1'b0;
    end else begin
      rMemEn <= 1'b0;
      rMemWr <= 1'b0;
      rDone  <= 1'b0;
      rErr   <= 1'b0;
      case (rState)
        IDLE: begin
          if (bus.iReqVld) begin
            if (wErr) begin
              rErr <= 1'b1;
            end else begin
              rOfs     <= wReqOfs;
              rSize    <= bus.iSize;
              rDat     <= bus.iDat;
              rMemEn   <= 1'b1;
              rMemAddr <= wReqWord;
              if (wFull) begin
                rState   <= WR;
                rMemWr   <= 1'b1;
                rMemWDat <= bus.iDat;
                rDone    <= 1'b1;
              end else begin
                rState <= RD;
              end
            end
          end
        end
        RD: begin
          rState <= MRG;
        end
        MRG: begin
          rState   <= WR;
          rMemEn   <= 1'b1;
          rMemWr   <= 1'b1;
          rMemWDat <= wMerged;
          rDone    <= 1'b1;
        end
        WR: begin
          rState <= IDLE;
        end
        default: begin
          rState <= IDLE;
        end
      endcase
    end
  end

  assign bus.oReqRdy  = (rState == IDLE);
  assign bus.oMemEn   = rMemEn;
  assign bus.oMemWr   = rMemWr;
  assign bus.oMemAddr = rMemAddr;
  assign bus.oMemWDat = rMemWDat;
  assign bus.oDone    = rDone;
  assign bus.oErr     = rErr;

endmodule

`default_nettype wire

// File: tb/tb_bc_dat_write_rmw.sv
// ============================================================================
// Module : tb_bc_dat_write_rmw
// Brief  : Directed bench for bc_dat_write_rmw at WIDTH_DATA=32 with SRAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bc_dat_write_rmw;
  logic clk;
  logic rst_n;

  bc_dat_write_rmw_if #(.WIDTH_DATA(32), .WIDTH_ADDR(10)) bus ();

  bc_dat_write_rmw #(.WIDTH_DATA(32), .WIDTH_ADDR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM: registered read, plus a bench-side preload port
  logic [31:0] mem [0:1023];
  logic        preEn;
  logic [9:0]  preAddr;
  logic [31:0] preDat;

  always @(posedge clk) begin
    if (preEn) mem[preAddr] <= preDat;
    if (bus.oMemEn && bus.oMemWr) mem[bus.oMemAddr] <= bus.oMemWDat;
    if (bus.oMemEn && !bus.oMemWr) bus.iMemRDat <= mem[bus.oMemAddr];
  end

  int nCmp  = 0;
  int nFail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    preEn = 1'b1; preAddr = a; preDat = d;
    cyc();
    preEn = 1'b0;
  endtask

  task automatic req(input logic [11:0] a, input logic [1:0] s, input logic [31:0] d);
    bus.iReqVld = 1'b1; bus.iAddr = a; bus.iSize = s; bus.iDat = d;
  endtask

  initial begin
    rst_n = 1'b0; preEn = 1'b0; preAddr = '0; preDat = '0;
    bus.iReqVld = 1'b0; bus.iAddr = '0; bus.iSize = '0; bus.iDat = '0;
    bus.iMemRDat = '0;
    cyc(); cyc();
    chk("rst_rdy",   bus.oReqRdy,  1);
    chk("rst_en",    bus.oMemEn,   0);
    chk("rst_wr",    bus.oMemWr,   0);
    chk("rst_addr",  bus.oMemAddr, 0);
    chk("rst_wdat",  bus.oMemWDat, 0);
    chk("rst_done",  bus.oDone,    0);
    chk("rst_err",   bus.oErr,     0);
    rst_n = 1'b1;
    preload(10'h10, 32'hAABBCCDD);

    // 1: byte store at 0x41
    req(12'h041, 2'd0, 32'h00000055);
    cyc();  // T+1
    bus.iReqVld = 1'b0;
    chk("t1_rd_en",   bus.oMemEn,   1);
    chk("t1_rd_wr",   bus.oMemWr,   0);
    chk("t1_rd_addr", bus.oMemAddr, 10'h10);
    chk("t1_rdy_lo",  bus.oReqRdy,  0);
    cyc();  // T+2
    chk("t1_mrg_en",  bus.oMemEn,   0);
    chk("t1_mrg_rdy", bus.oReqRdy,  0);
    cyc();  // T+3
    chk("t1_wr_en",   bus.oMemEn,   1);
    chk("t1_wr_wr",   bus.oMemWr,   1);
    chk("t1_wr_dat",  bus.oMemWDat, 32'hAABB55DD);
    chk("t1_done",    bus.oDone,    1);
    cyc();  // T+4
    chk("t1_rdy",     bus.oReqRdy,  1);
    chk("t1_done_lo", bus.oDone,    0);
    chk("t1_mem",     mem[10'h10],  32'hAABB55DD);

    // 2: halfword store at 0x42, upper data bits ignored
    preload(10'h10, 32'hAABBCCDD);
    req(12'h042, 2'd1, 32'hFFFF1234);
    cyc(); bus.iReqVld = 1'b0;
    cyc(); cyc();
    chk("t2_wr_dat", bus.oMemWDat, 32'h1234CCDD);
    chk("t2_done",   bus.oDone,    1);
    cyc();
    chk("t2_mem",    mem[10'h10],  32'h1234CCDD);

    // 3: full-word store at 0x40, no read
    req(12'h040, 2'd2, 32'hDEADBEEF);
    cyc(); bus.iReqVld = 1'b0;
    chk("t3_en",   bus.oMemEn,   1);
    chk("t3_wr",   bus.oMemWr,   1);
    chk("t3_addr", bus.oMemAddr, 10'h10);
    chk("t3_dat",  bus.oMemWDat, 32'hDEADBEEF);
    chk("t3_done", bus.oDone,    1);
    chk("t3_rdy",  bus.oReqRdy,  0);
    cyc();
    chk("t3_rdy2", bus.oReqRdy,  1);
    chk("t3_mem",  mem[10'h10],  32'hDEADBEEF);

    // 4: misaligned half, then dword on a 32-bit memory
    req(12'h043, 2'd1, 32'h00001111);
    cyc(); bus.iReqVld = 1'b0;
    chk("t4a_err",  bus.oErr,    1);
    chk("t4a_en",   bus.oMemEn,  0);
    chk("t4a_rdy",  bus.oReqRdy, 1);
    chk("t4a_done", bus.oDone,   0);
    cyc();
    chk("t4a_err_lo", bus.oErr,  0);
    req(12'h040, 2'd3, 32'h22222222);
    cyc(); bus.iReqVld = 1'b0;
    chk("t4b_err",  bus.oErr,    1);
    chk("t4b_en",   bus.oMemEn,  0);
    chk("t4b_rdy",  bus.oReqRdy, 1);
    cyc();
    chk("t4_mem",   mem[10'h10], 32'hDEADBEEF);

    // 5: valid held high through a partial store; next word store queued behind it
    preload(10'h10, 32'hAABBCCDD);
    req(12'h040, 2'd0, 32'h00000077);
    cyc();  // T+1
    req(12'h044, 2'd2, 32'h11223344);
    chk("t5_rdy1", bus.oReqRdy, 0);
    cyc();  // T+2
    chk("t5_rdy2", bus.oReqRdy, 0);
    cyc();  // T+3
    chk("t5_rdy3", bus.oReqRdy, 0);
    chk("t5_wdat", bus.oMemWDat, 32'hAABBCC77);
    cyc();  // T+4
    chk("t5_rdy4", bus.oReqRdy, 1);
    chk("t5_en4",  bus.oMemEn,  0);
    cyc();  // T+5
    bus.iReqVld = 1'b0;
    chk("t5_en5",   bus.oMemEn,   1);
    chk("t5_wr5",   bus.oMemWr,   1);
    chk("t5_addr5", bus.oMemAddr, 10'h11);
    chk("t5_dat5",  bus.oMemWDat, 32'h11223344);
    chk("t5_done5", bus.oDone,    1);
    cyc();
    chk("t5_mem10", mem[10'h10], 32'hAABBCC77);
    chk("t5_mem11", mem[10'h11], 32'h11223344);

    // 6: reset pulsed during MRG drops the store
    preload(10'h10, 32'hAABBCCDD);
    req(12'h041, 2'd0, 32'h00000055);
    cyc(); bus.iReqVld = 1'b0;
    cyc();  // T+2, MRG
    rst_n = 1'b0;
    #1;
    chk("t6_en",   bus.oMemEn,   0);
    chk("t6_wr",   bus.oMemWr,   0);
    chk("t6_addr", bus.oMemAddr, 0);
    chk("t6_done", bus.oDone,    0);
    chk("t6_rdy",  bus.oReqRdy,  1);
    cyc(); cyc();
    chk("t6_en2",  bus.oMemEn,   0);
    chk("t6_mem",  mem[10'h10],  32'hAABBCCDD);
    rst_n = 1'b1;
    cyc();
    req(12'h042, 2'd0, 32'hABCDEF99);
    cyc(); bus.iReqVld = 1'b0;
    chk("t6b_rd", bus.oMemEn & ~bus.oMemWr, 1);
    cyc(); cyc();
    chk("t6b_dat",  bus.oMemWDat, 32'hAA99CCDD);
    chk("t6b_done", bus.oDone,    1);
    cyc();
    chk("t6b_mem",  mem[10'h10],  32'hAA99CCDD);
    chk("t6b_rdy",  bus.oReqRdy,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule

`default_nettype wire
